alu_arbiter: RTL

- Two-port request arbiter and sequencer for the shared 32-bit ALU (one-hot 7-bit op select, 32-bit result, 4-bit NZCV flags).
- Accepts operand/op requests from two masters with round-robin fairness and drives the ALU from registered operands.
- Captures the result and flags, returns them to the granted master with a one-cycle response strobe, and maintains an architectural NZCV flag register.

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter and sequencer for a shared ALU: grants one
// request at a time, drives registered operands, returns result/flags and keeps NZCV.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic [3:0]       resp_flags,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_data,
  input  logic [3:0]       alu_flag,
  output logic [3:0]       flag_reg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             owner;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             sel_legal;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [SEL_W-1:0] win_sel;

  // Winner selection: a lone valid port wins; on a tie the port that was
  // not granted last time wins. Ready is held low while reset is asserted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && (state == ST_IDLE)) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  always_comb begin
    win_a   = req0_a;
    win_b   = req0_b;
    win_sel = req0_sel;
    if (grant1) begin
      win_a   = req1_a;
      win_b   = req1_b;
      win_sel = req1_sel;
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_legal = (alu_sel != '0) && ((alu_sel & (alu_sel - SEL_W'(1))) == '0);

  assign resp0_valid = (state == ST_RESP) && !owner;
  assign resp1_valid = (state == ST_RESP) && owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      resp_data  <= '0;
      resp_flags <= '0;
      resp_err   <= 1'b0;
      flag_reg   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a      <= win_a;
            alu_b      <= win_b;
            alu_sel    <= win_sel;
            owner      <= grant1;
            last_grant <= grant1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Illegal selects still complete, but with a zeroed result and
          // without disturbing the architectural flags.
          if (sel_legal) begin
            resp_data  <= alu_data;
            resp_flags <= alu_flag;
            resp_err   <= 1'b0;
            flag_reg   <= alu_flag;
          end else begin
            resp_data  <= '0;
            resp_flags <= '0;
            resp_err   <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          alu_sel <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          alu_sel <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
